// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, oversampling ratio and the legal
// stop-bit lengths. The transmit and receive controllers both use them.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } uart_state_e;

  // Baud ticks per bit period.
  localparam int OVERSAMPLE = 16;

  // Stop-bit lengths in baud ticks: 1, 1.5 and 2 stop bits.
  localparam int SB_TICKS_1   = 16;
  localparam int SB_TICKS_1P5 = 24;
  localparam int SB_TICKS_2   = 32;

  function automatic bit sb_ticks_legal(input int sb);
    return (sb == SB_TICKS_1) || (sb == SB_TICKS_1P5) || (sb == SB_TICKS_2);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running baud divider: counts 0..BaudDiv-1 and flags the last count
// as a one-cycle tick. A synchronous clear restarts the count from zero so
// that a new frame is phase-aligned to its accept edge.
module baud_tick_gen #(
  parameter int BaudDiv  = 325,
  parameter int DivWidth = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam logic [DivWidth-1:0] LastCount = DivWidth'(BaudDiv - 1);

  logic [DivWidth-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise wrap after the last count.
  always_comb begin
    tick  = (cnt_q == LastCount);
    cnt_d = cnt_q + DivWidth'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serializes one word per request into a frame
// of start bit, DataBits data bits (LSB first) and a SbTicks-long stop.
//
// Handshake: a request is accepted on any rising edge where tx_start_i and
// tx_ready_o are both 1; din_i is sampled on that edge. Requests seen while
// tx_ready_o=0 are dropped. tx_ready_o is also high in the final cycle of
// the stop bit (together with tx_done_tick_o), so a held request starts the
// next frame with no idle gap.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DataBits = 8,
  parameter int SbTicks  = 16,
  parameter int BaudDiv  = 325,
  parameter int DivWidth = 9
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tx_start_i,
  input  logic [DataBits-1:0] din_i,
  output logic                tx_ready_o,
  output logic                tx_done_tick_o,
  output logic                tx_o,
  output logic [1:0]          state_o
);

  localparam int BitCntW = (DataBits > 1) ? $clog2(DataBits) : 1;
  localparam logic [BitCntW-1:0] LastBit      = BitCntW'(DataBits - 1);
  localparam logic [5:0]         LastBitTick  = 6'(OVERSAMPLE - 1);
  localparam logic [5:0]         LastStopTick = 6'(SbTicks - 1);

  uart_state_e          state_q, state_d;
  logic [5:0]           tick_cnt_q, tick_cnt_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DataBits-1:0]  shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 baud_tick;
  logic                 div_clear;
  logic                 ready;
  logic                 done;
  logic                 accept;

  baud_tick_gen #(
    .BaudDiv  (BaudDiv),
    .DivWidth (DivWidth)
  ) u_baud (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clear (div_clear),
    .tick  (baud_tick)
  );

  // Next-state, counters, shifter and line level; tx_d follows the state
  // being entered so the line register changes on the same edge as the FSM.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = 1'b1;
    ready      = 1'b0;
    done       = 1'b0;
    div_clear  = 1'b0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
      end
      START: begin
        if (baud_tick) begin
          if (tick_cnt_q == LastBitTick) begin
            state_d    = DATA;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 6'd1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_cnt_q == LastBitTick) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == LastBit) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BitCntW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 6'd1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (tick_cnt_q == LastStopTick) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            done       = 1'b1;
            ready      = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept = ready && tx_start_i;
    if (accept) begin
      state_d    = START;
      shift_d    = din_i;
      tick_cnt_d = '0;
      div_clear  = 1'b1;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State, counters, shift register and the registered serial line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o           = tx_q;
  assign tx_ready_o     = ready;
  assign tx_done_tick_o = done;
  assign state_o        = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with BaudDiv=4: instance a is 8 data bits / 1 stop
// bit, instance b is 5 data bits / 2 stop bits. Expected line levels are
// queued when a frame is requested and popped as the line is sampled.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int BAUD    = 4;
  localparam int BIT_CYC = OVERSAMPLE * BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] din_a = '0;
  logic [4:0] din_b = '0;
  logic       ready_a, done_a, tx_a;
  logic       ready_b, done_b, tx_b;
  logic [1:0] state_a, state_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  logic [0:0] exp_q[$];

  uart_tx_ctrl #(.DataBits(8), .SbTicks(16), .BaudDiv(BAUD), .DivWidth(3)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .tx_start_i(start_a), .din_i(din_a),
    .tx_ready_o(ready_a), .tx_done_tick_o(done_a), .tx_o(tx_a), .state_o(state_a)
  );

  uart_tx_ctrl #(.DataBits(5), .SbTicks(32), .BaudDiv(BAUD), .DivWidth(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .tx_start_i(start_b), .din_i(din_b),
    .tx_ready_o(ready_b), .tx_done_tick_o(done_b), .tx_o(tx_b), .state_o(state_b)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? ready_a : ready_b;
  endfunction

  // expected line levels: start, data LSB first, stop
  task automatic push_frame(input logic [7:0] data, input int nbits);
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) exp_q.push_back(data[i]);
    exp_q.push_back(1'b1);
  endtask

  // driver: wait for ready, present one request for one edge
  task automatic drive_start(input int sel, input logic [7:0] data);
    int t;
    t = 0;
    @(negedge clk);
    while (ready_of(sel) !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (ready_of(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL start_wait: tx_ready_o=%b after %0d cycles, expected 1", ready_of(sel), t);
    end
    if (sel == 0) begin
      start_a = 1'b1;
      din_a   = data;
    end else begin
      start_b = 1'b1;
      din_b   = data[4:0];
    end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // scoreboard: find the start-bit fall, then check the first and last
  // cycle of every bit slot against the queue and the done pulse position.
  // Returns at the negedge of the final stop cycle.
  task automatic check_frame(input int sel, input int nbits, input int sb,
                             input string name, output int fall);
    int t;
    int len;
    int dones;
    logic [0:0] exp;
    logic v;
    t = 0;
    fall = -1;
    dones = 0;
    do begin
      @(negedge clk);
      t++;
    end while (tx_of(sel) !== 1'b0 && t < 3000);
    n_cmp++;
    if (tx_of(sel) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_fall: tx_o=%b after %0d cycles, expected 0", name, tx_of(sel), t);
      exp_q.delete();
      return;
    end
    fall = cyc;
    for (int i = 0; i < nbits + 2; i++) begin
      len = (i == nbits + 1) ? sb * BAUD : BIT_CYC;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      for (int c = 0; c < len; c++) begin
        v = tx_of(sel);
        if (done_of(sel) === 1'b1) dones++;
        if (c == 0 || c == len - 1) begin
          n_cmp++;
          if (v !== exp[0]) begin
            n_fail++;
            $display("FAIL %s_slot%0d: tx_o=%b at offset %0d, expected %b", name, i, v, c, exp[0]);
          end
        end
        if (!(i == nbits + 1 && c == len - 1)) @(negedge clk);
      end
    end
    n_cmp++;
    if (done_of(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_pos: tx_done_tick_o=%b in last stop cycle, expected 1", name, done_of(sel));
    end
    n_cmp++;
    if (ready_of(sel) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_end: tx_ready_o=%b in last stop cycle, expected 1", name, ready_of(sel));
    end
    n_cmp++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL %s_done_cnt: %0d done pulses, expected 1", name, dones);
    end
  endtask

  // quiet line on both instances for ncyc cycles
  task automatic check_idle(input int ncyc, input string name);
    int bad;
    bad = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || tx_b !== 1'b1 || done_a !== 1'b0 || done_b !== 1'b0 ||
          ready_a !== 1'b1 || ready_b !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s: %0d non-idle cycles, expected 0", name, bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (tx_a !== 1'b1)    begin n_fail++; $display("FAIL rst_tx_a: got %b expected 1", tx_a); end
    n_cmp++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL rst_ready_a: got %b expected 1", ready_a); end
    n_cmp++; if (done_a !== 1'b0)  begin n_fail++; $display("FAIL rst_done_a: got %b expected 0", done_a); end
    n_cmp++; if (state_a !== ST_IDLE) begin n_fail++; $display("FAIL rst_state_a: got %0d expected 0", state_a); end
    n_cmp++; if (tx_b !== 1'b1)    begin n_fail++; $display("FAIL rst_tx_b: got %b expected 1", tx_b); end
    n_cmp++; if (ready_b !== 1'b1) begin n_fail++; $display("FAIL rst_ready_b: got %b expected 1", ready_b); end
    rst_n = 1'b1;
    check_idle(200, "rst_idle");
  endtask

  task automatic test_single_frame();
    int f;
    push_frame(8'hA5, 8);
    drive_start(0, 8'hA5);
    check_frame(0, 8, 16, "a5", f);
    check_idle(20, "a5_after");
  endtask

  task automatic test_back_to_back();
    int f1, f2;
    push_frame(8'h00, 8);
    push_frame(8'hFF, 8);
    fork
      begin
        @(negedge clk);
        start_a = 1'b1;
        din_a   = 8'h00;
        @(posedge clk);
        #1 din_a = 8'hFF;
        repeat (9 * BIT_CYC + 16 * BAUD) @(posedge clk);
        #1 start_a = 1'b0;
      end
      begin
        check_frame(0, 8, 16, "b2b0", f1);
        check_frame(0, 8, 16, "b2b1", f2);
      end
    join
    n_cmp++;
    if (f2 - f1 !== 9 * BIT_CYC + 16 * BAUD) begin
      n_fail++;
      $display("FAIL b2b_spacing: fall-to-fall %0d cycles, expected %0d", f2 - f1, 9 * BIT_CYC + 16 * BAUD);
    end
    check_idle(20, "b2b_after");
  endtask

  task automatic test_ignored_request();
    int f;
    push_frame(8'h5A, 8);
    drive_start(0, 8'h5A);
    fork
      begin
        repeat (200) @(posedge clk);
        #1;
        start_a = 1'b1;
        din_a   = 8'h3C;
        @(posedge clk);
        #1 start_a = 1'b0;
      end
      check_frame(0, 8, 16, "ign", f);
    join
    check_idle(100, "ign_after");
  endtask

  task automatic test_reset_mid_frame();
    int f;
    int t;
    t = 0;
    drive_start(0, 8'hA5);
    do begin
      @(negedge clk);
      t++;
    end while (tx_a !== 1'b0 && t < 100);
    // into data bit 3 (slot 4), which carries a 0 for 0xA5
    repeat (4 * BIT_CYC + 20) @(negedge clk);
    n_cmp++;
    if (tx_a !== 1'b0 || state_a !== ST_DATA) begin
      n_fail++;
      $display("FAIL mid_pre: tx_o=%b state=%0d, expected 0 and %0d", tx_a, state_a, ST_DATA);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx_a !== 1'b1)    begin n_fail++; $display("FAIL mid_rst_tx: got %b expected 1", tx_a); end
    n_cmp++; if (done_a !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_done: got %b expected 0", done_a); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL mid_rel_ready: got %b expected 1", ready_a); end
    n_cmp++; if (state_a !== ST_IDLE) begin n_fail++; $display("FAIL mid_rel_state: got %0d expected 0", state_a); end
    check_idle(100, "mid_idle");
    push_frame(8'h3C, 8);
    drive_start(0, 8'h3C);
    check_frame(0, 8, 16, "mid_next", f);
  endtask

  task automatic test_stop_width();
    int f;
    push_frame(8'h15, 5);
    drive_start(1, 8'h15);
    check_frame(1, 5, 32, "w5s2", f);
    check_idle(20, "w5s2_after");
  endtask

  task automatic test_random();
    int f;
    logic [7:0] d;
    for (int n = 0; n < 2; n++) begin
      d = 8'($urandom_range(0, 255));
      push_frame(d, 8);
      drive_start(0, d);
      check_frame(0, 8, 16, "rnd_a", f);
      d = 8'($urandom_range(0, 31));
      push_frame(d, 5);
      drive_start(1, d);
      check_frame(1, 5, 32, "rnd_b", f);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignored_request();
    test_reset_mid_frame();
    test_stop_width();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that serializes one parallel data word per request into an 8N1-style asynchronous frame. It owns its baud-rate tick divider and sequences it (clears it on frame start, consumes its ticks at 16x oversampling). It sits between the user-side byte producer and the `tx` pad, alongside the receive path that shares the same baud settings.

## Interface
- `DataBits`, 8: data bits per frame, range 5..8.
- `SbTicks`, 16: stop-bit length in baud ticks; legal values are 16 (1 stop bit), 24 (1.5) and 32 (2).
- `BaudDiv`, 325: clock cycles per baud tick (16x oversample). 325 gives 9600 baud at 50 MHz. Must be at least 2.
- `DivWidth`, 9: divider counter width. Requires BaudDiv ≤ 2**DivWidth.

Ports:
- `clk_i` in, 1: single clock; all logic is on the rising edge.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `tx_start_i` in, 1: frame request; accepted only while `tx_ready_o`=1.
- `din_i` in, DataBits: word to send; sampled on accept.
- `tx_ready_o` out, 1: controller idle and able to accept.
- `tx_done_tick_o` out, 1: one-cycle pulse after the stop bit completes.
- `tx_o` out, 1: serial line; registered, idle high.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- Reset values: state=IDLE, `tx_o`=1, `tx_ready_o`=1, `tx_done_tick_o`=0. The divider, tick counter and bit counter all reset to 0.
- **IDLE**
  - `tx_ready_o`=1 and `tx_o`=1.
  - Accept occurs on an edge where `tx_start_i`=1. On accept: latch `din_i` into the shift register, clear the divider and tick counter, and go to START.
- **START**: `tx_o`=0 for 16 baud ticks, then go to DATA with bit counter=0.
- **DATA**
  - `tx_o`=shift[0], sent LSB first.
  - After 16 ticks: shift right and increment the bit counter.
  - After bit DataBits-1: go to STOP.
- **STOP**: `tx_o`=1 for SbTicks ticks, then go to IDLE and pulse `tx_done_tick_o`.
- Baud divider behaviour:
  - Counts 0..BaudDiv-1 and wraps.
  - tick = (count == BaudDiv-1).
  - Free-running in all states. It is cleared only by accept or reset.
- Tick counter: 6 bits. It is cleared at every state or bit boundary.
- Ignored inputs:
  - `tx_start_i` while not ready is dropped, with no queuing.
  - `din_i` changes after accept have no effect on the frame in flight.
- Reset mid-frame: `tx_o` returns to 1 asynchronously and the state goes to IDLE. The partial frame is discarded and no done pulse is issued.

## Timing
- Bit period = 16·BaudDiv cycles. Stop period = SbTicks·BaudDiv cycles.
- Accept on edge k: `tx_o` falls and `tx_ready_o` falls, both visible after edge k.
- Each `tx_o` transition occurs exactly one bit period after the previous one. There is no jitter, because the divider is cleared at accept.
- Frame length from the `tx_o` fall to the return to IDLE = (1+DataBits)·16·BaudDiv + SbTicks·BaudDiv cycles. With defaults this is 52000 cycles.
- The cycle that returns to IDLE has `tx_ready_o`=1 and `tx_done_tick_o`=1 simultaneously. An accept in that same cycle is legal (back-to-back), so the next start bit follows the stop bit with zero extra idle cycles.
- Start-to-serial latency is 1 cycle.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - `OVERSAMPLE`=16;
  - the legal SbTicks values.
  The receive controller reuses these.
- Sub-module `baud_tick_gen` holds the divider, with ports clk, rst_n, clear, tick and parameters BaudDiv/DivWidth. The controller drives `clear` on accept.
- The top level contains the FSM, tick counter, bit counter, shift register and the `tx_o` register.

## Test plan
- **Reset values.** BaudDiv=4. Hold `rst_ni`=0 for 3 cycles → `tx_o`=1, `tx_ready_o`=1, `tx_done_tick_o`=0. Then no activity for 200 cycles.
- **Single frame 0xA5.**
  - Stimulus: BaudDiv=4, DataBits=8, SbTicks=16.
  - `tx_o` reads 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop). Each bit lasts 64 cycles.
  - `tx_done_tick_o` is a single pulse 640 cycles after the `tx_o` fall.
- **Back-to-back frames.** Hold `tx_start_i`=1 with din 0x00, then 0xFF → second start bit begins the cycle after the done pulse. The stop-to-start gap is exactly 64 cycles high.
- **Ignored request.** Pulse `tx_start_i` with din=0x3C mid-frame → no effect; the frame in flight is unchanged and exactly one done pulse occurs.
- **Reset mid-frame.** Assert `rst_ni`=0 during DATA bit 3 → `tx_o`=1 asynchronously and `tx_ready_o`=1 on release. No done pulse; the next frame transmits correctly.
- **Stop length and data width.** Use SbTicks=32, DataBits=5, din=0x15 → data bits 1,0,1,0,1, then a stop-high period of 128 cycles before the done pulse.
